// File: rtl/push_sched_pkg.sv
// -----------------------------------------------------------------------------
// push_sched_pkg
// Shared definitions for the push-switch event scheduler: the FSM state
// encoding and a constant-foldable ceiling-log2 helper used to size counters
// and index fields.
// -----------------------------------------------------------------------------
package push_sched_pkg;

    localparam int         STATE_W   = 2;
    localparam logic [1:0] ST_IDLE_V = 2'd0;
    localparam logic [1:0] ST_HOLD_V = 2'd1;
    localparam logic [1:0] ST_GAP_V  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = ST_IDLE_V,
        ST_HOLD = ST_HOLD_V,
        ST_GAP  = ST_GAP_V
    } state_t;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int CLOG2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/debounce_switch.sv
// -----------------------------------------------------------------------------
// debounce_switch
// Synchronizes a raw mechanical switch into the clk domain and only lets the
// output level follow once the synchronized input has held a new value for
// STABLE_CYCLES consecutive cycles.
//   clk    in  system clock
//   rstb   in  asynchronous active-low reset
//   sw     in  raw switch level
//   level  out debounced level (resets to 0)
// -----------------------------------------------------------------------------
module debounce_switch
    import push_sched_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstb,
    input  logic sw,
    output logic level
);

    localparam int CW = CLOG2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
            // Any bounce back to the current level restarts the stability window.
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                level      <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/push_event_capture.sv
// -----------------------------------------------------------------------------
// push_event_capture
// One channel of press capture: conditioning (debouncer or plain 2-flop
// synchronizer), rising-edge detect, and the pending / sticky-overrun flags.
//   clk   in  system clock
//   rstb  in  asynchronous active-low reset
//   sw    in  raw push switch, active-high
//   clr   in  channel is being granted this cycle (clears pending)
//   pend  out press event waiting for service
//   ovf   out sticky: a press was merged into an already pending event
// -----------------------------------------------------------------------------
module push_event_capture
    import push_sched_pkg::*;
#(
    parameter int DEBOUNCE_EN     = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstb,
    input  logic sw,
    input  logic clr,
    output logic pend,
    output logic ovf
);

    logic d;
    logic prev;
    logic edge_det;

    generate
        if (DEBOUNCE_EN != 0) begin : g_debounce
            debounce_switch #(
                .STABLE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rstb  (rstb),
                .sw    (sw),
                .level (d)
            );
        end else begin : g_sync
            logic sync_q1;
            logic sync_q2;

            // NOTE: sequential state is written with <= so every flop samples
            // the pre-edge value of its neighbours and the pipeline shifts.
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    sync_q1 <= 1'b0;
                    sync_q2 <= 1'b0;
                end else begin
                    sync_q1 <= sw;
                    sync_q2 <= sync_q1;
                end
            end

            assign d = sync_q2;
        end
    endgenerate

    // prev resets to 0, so a switch held through reset still produces exactly
    // one edge once d rises afterwards.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign edge_det = d & ~prev;

    // A new edge wins over the grant clear; an edge hitting a pending event
    // that is not being cleared is merged and flagged as an overrun.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (edge_det) begin
                if (pend && !clr) begin
                    ovf <= 1'b1;
                end
                pend <= 1'b1;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/push_event_scheduler.sv
// -----------------------------------------------------------------------------
// push_event_scheduler
// Round-robin sharing of one LED bank between N push-switch requesters. Each
// press becomes a pending event; events are served one at a time by lighting
// the owner's LED for HOLD_CYCLES, then blanking for GAP_CYCLES.
//   clk       in  system clock
//   rstb      in  asynchronous active-low reset
//   PUSH_SW   in  [N]  raw push switches, active-high
//   LED       out [N]  one-hot while serving a channel, else zero
//   busy      out      high in HOLD or GAP, aligned with LED
//   grant_id  out      index of the last granted channel
//   ovf       out [N]  sticky per-channel overrun flags
// -----------------------------------------------------------------------------
module push_event_scheduler
    import push_sched_pkg::*;
#(
    parameter int N               = 4,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int GAP_CYCLES      = 2_500_000,
    parameter int DEBOUNCE_EN     = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [N-1:0]          PUSH_SW,
    output logic [N-1:0]          LED,
    output logic                  busy,
    output logic [CLOG2(N)-1:0]   grant_id,
    output logic [N-1:0]          ovf
);

    localparam int ID_W    = CLOG2(N);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = CLOG2(CNT_MAX + 1);
    localparam int GAP_RAW = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_RAW);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [N-1:0]     pend;
    logic [N-1:0]     clr;

    logic             any_pend;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  idx;
    logic [N-1:0]     sel_onehot;
    logic             do_grant;

    // ---------------------------------------------------------------- capture
    for (genvar i = 0; i < N; i++) begin : g_ch
        push_event_capture #(
            .DEBOUNCE_EN     (DEBOUNCE_EN),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_capture (
            .clk  (clk),
            .rstb (rstb),
            .sw   (PUSH_SW[i]),
            .clr  (clr[i]),
            .pend (pend[i]),
            .ovf  (ovf[i])
        );
    end

    // ------------------------------------------------------ round-robin search
    // Scan ptr, ptr+1, ... wrapping at N; the first pending channel wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned and no latch is inferred.
        any_pend = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int off = 0; off < N; off++) begin
            idx = ID_W'((int'(ptr) + off) % N);
            if (!any_pend && pend[idx]) begin
                any_pend = 1'b1;
                sel      = idx;
            end
        end
    end

    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
    assign do_grant   = (state == ST_IDLE) && any_pend;
    assign clr        = do_grant ? sel_onehot : '0;

    // -------------------------------------------------------------------- FSM
    // LED and busy are registered alongside the state so they change on the
    // same edge as the state they decode.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: the asynchronous reset clears LED/busy directly, so a reset
        // in the middle of a hold blanks the LEDs without waiting for a clock.
        if (!rstb) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            grant_id <= '0;
            LED      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_grant) begin
                        grant_id <= sel;
                        ptr      <= (sel == LAST_ID) ? '0 : sel + 1'b1;
                        cnt      <= HOLD_LOAD;
                        LED      <= sel_onehot;
                        busy     <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        LED <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    LED   <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_push_event_scheduler
// Directed scenarios followed by randomized press traffic. The reference model
// works in terms of service windows: a grant at edge t owns the LED for edges
// t..t+H-1, keeps busy through t+H+G-1, and the next grant may happen at
// t+H+G+1. Raw presses reach the pending set two edges after being sampled.
// -----------------------------------------------------------------------------
module tb_push_event_scheduler;

    localparam int N = 4;
    localparam int H = 4;
    localparam int G = 2;

    logic         clk;
    logic         rstb;
    logic [N-1:0] PUSH_SW;
    logic [N-1:0] LED;
    logic         busy;
    logic [1:0]   grant_id;
    logic [N-1:0] ovf;

    push_event_scheduler #(
        .N           (N),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .DEBOUNCE_EN (0)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .PUSH_SW  (PUSH_SW),
        .LED      (LED),
        .busy     (busy),
        .grant_id (grant_id),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------ model state
    int           e;            // edges since reset release
    logic [N-1:0] hist [4];     // raw samples: hist[k] taken at edge e-k
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    int           m_ptr;
    int           m_gid;
    int           m_t;          // edge of the latest grant
    bit           m_granted;
    int           m_free;       // earliest edge at which a grant may happen
    logic [N-1:0] exp_led;
    logic         exp_busy;
    logic [N-1:0] led_prev;
    int           grants [$];   // observed service order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) hist[k] = '0;
        m_pend    = '0;
        m_ovf     = '0;
        m_ptr     = 0;
        m_gid     = 0;
        m_t       = 0;
        m_granted = 1'b0;
        m_free    = 0;
        led_prev  = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] ev;
        logic [N-1:0] mclr;
        bit           found;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = PUSH_SW;
        ev   = hist[2] & ~hist[3];
        mclr = '0;
        if (e >= m_free && m_pend != '0) begin
            found = 1'b0;
            for (int off = 0; off < N; off++) begin
                if (!found && m_pend[(m_ptr + off) % N]) begin
                    found = 1'b1;
                    m_gid = (m_ptr + off) % N;
                end
            end
            mclr[m_gid] = 1'b1;
            m_ptr     = (m_gid + 1) % N;
            m_t       = e;
            m_granted = 1'b1;
            m_free    = e + H + G + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (m_pend[i] && !mclr[i]) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
            end else if (mclr[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        exp_led  = (m_granted && e >= m_t && e < m_t + H) ? (N'(1) << m_gid) : '0;
        exp_busy = m_granted && (e < m_t + H + G);
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_edge();
        #1;
        check($sformatf("led@%0d", e),   32'(LED),      32'(exp_led));
        check($sformatf("busy@%0d", e),  32'(busy),     32'(exp_busy));
        check($sformatf("gid@%0d", e),   32'(grant_id), 32'(m_gid));
        check($sformatf("ovf@%0d", e),   32'(ovf),      32'(m_ovf));
        if (LED != '0 && led_prev == '0) grants.push_back(int'(grant_id));
        led_prev = LED;
    endtask

    task automatic run_until(input int target);
        while (e < target) step();
    endtask

    // Asserts reset, checks the outputs before any clock edge, then releases.
    task automatic do_reset(input logic [N-1:0] held);
        rstb    = 1'b0;
        PUSH_SW = held;
        #1;
        check("rst_led",  32'(LED),      32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_gid",  32'(grant_id), 32'd0);
        check("rst_ovf",  32'(ovf),      32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        e    = 0;
        grants.delete();
    endtask

    initial begin
        rstb    = 1'b0;
        PUSH_SW = '0;
        e       = 0;
        model_reset();

        // ---- single press on ch2 sampled at edges 10..11
        do_reset('0);
        run_until(9);  PUSH_SW = 4'b0100;
        run_until(11); PUSH_SW = 4'b0000;
        run_until(12); check("single_led12", 32'(LED), 32'h0);
        run_until(13); check("single_led13", 32'(LED), 32'h4);
                       check("single_gid",   32'(grant_id), 32'd2);
        run_until(16); check("single_led16", 32'(LED), 32'h4);
        run_until(17); check("single_led17", 32'(LED), 32'h0);
                       check("single_busy17", 32'(busy), 32'd1);
        run_until(18); check("single_busy18", 32'(busy), 32'd1);
        run_until(19); check("single_busy19", 32'(busy), 32'd0);
        run_until(30); check("single_count", 32'(grants.size()), 32'd1);

        // ---- simultaneous presses 0,1,3
        do_reset('0);
        run_until(9);  PUSH_SW = 4'b1011;
        run_until(11); PUSH_SW = 4'b0000;
        run_until(13); check("simul_led13", 32'(LED), 32'h1);
        run_until(19); check("simul_led19", 32'(LED), 32'h0);
        run_until(20); check("simul_led20", 32'(LED), 32'h2);
        run_until(27); check("simul_led27", 32'(LED), 32'h8);
        run_until(40);
        check("simul_count", 32'(grants.size()), 32'd3);
        check("simul_g0", 32'(grants[0]), 32'd0);
        check("simul_g1", 32'(grants[1]), 32'd1);
        check("simul_g2", 32'(grants[2]), 32'd3);
        check("simul_ovf", 32'(ovf), 32'h0);

        // ---- fairness: ch0 re-pressed during each service, ch2 pressed once
        do_reset('0);
        run_until(9);  PUSH_SW = 4'b0001;
        run_until(11); PUSH_SW = 4'b0000;
        run_until(13); PUSH_SW = 4'b0101;
        run_until(15); PUSH_SW = 4'b0000;
        run_until(21); PUSH_SW = 4'b0001;
        run_until(23); PUSH_SW = 4'b0000;
        run_until(45);
        check("fair_count", 32'(grants.size()), 32'd3);
        check("fair_g1", 32'(grants[1]), 32'd2);
        check("fair_g2", 32'(grants[2]), 32'd0);

        // ---- overrun on ch1 while ch0 is served
        do_reset('0);
        run_until(6);  PUSH_SW = 4'b0001;
        run_until(8);  PUSH_SW = 4'b0000;
        run_until(9);  PUSH_SW = 4'b0010;
        run_until(10); PUSH_SW = 4'b0000;
        run_until(13); PUSH_SW = 4'b0010;
        run_until(14); PUSH_SW = 4'b0000;
        run_until(15); check("ovr_ovf15", 32'(ovf), 32'h0);
        run_until(16); check("ovr_ovf16", 32'(ovf), 32'h2);
        run_until(35);
        check("ovr_count", 32'(grants.size()), 32'd2);
        check("ovr_g1", 32'(grants[1]), 32'd1);

        // ---- ch1 edge in the same cycle ch1 is granted
        do_reset('0);
        run_until(6);  PUSH_SW = 4'b0001;
        run_until(7);  PUSH_SW = 4'b0010;
        run_until(8);  PUSH_SW = 4'b0000;
        run_until(14); PUSH_SW = 4'b0010;
        run_until(15); PUSH_SW = 4'b0000;
        run_until(17); check("coll_led17", 32'(LED), 32'h2);
        run_until(24); check("coll_led24", 32'(LED), 32'h2);
        run_until(40);
        check("coll_count", 32'(grants.size()), 32'd3);
        check("coll_g2", 32'(grants[2]), 32'd1);
        check("coll_ovf", 32'(ovf), 32'h0);

        // ---- reset two cycles into HOLD, with another event pending
        do_reset('0);
        run_until(9);  PUSH_SW = 4'b0100;
        run_until(10); PUSH_SW = 4'b0001;
        run_until(11); PUSH_SW = 4'b0000;
        run_until(15); check("mid_led15", 32'(LED), 32'h4);
        do_reset('0);
        run_until(30);
        check("mid_no_service", 32'(grants.size()), 32'd0);
        PUSH_SW = 4'b1010;
        run_until(32); PUSH_SW = 4'b0000;
        run_until(50);
        check("mid_count", 32'(grants.size()), 32'd2);
        check("mid_g0", 32'(grants[0]), 32'd1);
        check("mid_g1", 32'(grants[1]), 32'd3);

        // ---- randomized traffic, switches possibly held through reset
        for (int round = 0; round < 4; round++) begin
            do_reset(N'($urandom));
            for (int c = 0; c < 400; c++) begin
                logic [N-1:0] flip;
                flip = '0;
                for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
                PUSH_SW = PUSH_SW ^ flip;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
